// File: rtl/aes_v3_2_col_seq.sv
// Column sequencer: steps one shared single-byte AES datapath over four byte positions,
// XOR-accumulating the results into a full-column SubBytes / MixColumns / both, plus key.
module aes_v3_2_col_seq #(
    parameter bit SUBMIX_EN = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_dec,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_data,
    input  logic [31:0] req_key,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {StIdle, StSub, StMix, StDone} state_e;

    localparam logic [1:0] OpSub    = 2'b00;
    localparam logic [1:0] OpMix    = 2'b01;
    localparam logic [1:0] OpSubMix = 2'b10;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254: the chain x^(2^k - 1) reaches x^127 after six steps, one more square gives x^254.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Single-byte unit: byte bs of rs1 -> S-box (or MixColumns column contribution),
    // rotated into position bs, XORed with rs2.
    function automatic logic [31:0] byte_unit(input logic [31:0] rs1, input logic [31:0] rs2,
                                              input logic [1:0] bs, input logic dec,
                                              input logic mix, input logic valid);
        logic [7:0]  x;
        logic [7:0]  s;
        logic [31:0] w;
        logic [31:0] r;
        unique case (bs)
            2'd0:    x = rs1[7:0];
            2'd1:    x = rs1[15:8];
            2'd2:    x = rs1[23:16];
            default: x = rs1[31:24];
        endcase
        s = dec ? sbox_inv(x) : sbox_fwd(x);
        if (!mix) begin
            w = {24'h000000, s};
        end else if (dec) begin
            w = {gf_mul(x, 8'h0b), gf_mul(x, 8'h0d), gf_mul(x, 8'h09), gf_mul(x, 8'h0e)};
        end else begin
            w = {gf_mul(x, 8'h03), x, x, gf_mul(x, 8'h02)};
        end
        unique case (bs)
            2'd0:    r = w;
            2'd1:    r = {w[23:0], w[31:24]};
            2'd2:    r = {w[15:0], w[31:16]};
            default: r = {w[7:0], w[31:8]};
        endcase
        return valid ? (r ^ rs2) : 32'h0;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] work_q, work_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] key_q, key_d;
    logic        dec_q, dec_d;
    logic [1:0]  op_q, op_d;
    logic        err_q, err_d;

    logic        dp_valid;
    logic        dp_dec;
    logic        dp_mix;
    logic [31:0] dp_rs1;
    logic [31:0] dp_rs2;
    logic [1:0]  dp_bs;
    logic [31:0] dp_rd;
    logic        op_legal;

    assign op_legal = (req_op == OpSub) || (req_op == OpMix) || (req_op == OpSubMix && SUBMIX_EN);

    // Datapath inputs are zeroed outside the working states.
    always_comb begin
        dp_valid = (state_q == StSub) || (state_q == StMix);
        dp_mix   = (state_q == StMix);
        dp_dec   = dp_valid & dec_q;
        dp_rs1   = dp_valid ? work_q : 32'h0;
        dp_rs2   = 32'h0;
        dp_bs    = dp_valid ? cnt_q : 2'd0;
        dp_rd    = byte_unit(dp_rs1, dp_rs2, dp_bs, dp_dec, dp_mix, dp_valid);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        acc_d   = acc_q;
        key_d   = key_q;
        dec_d   = dec_q;
        op_d    = op_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    dec_d  = req_dec;
                    op_d   = req_op;
                    work_d = req_data;
                    key_d  = req_key;
                    cnt_d  = 2'd0;
                    if (!op_legal) begin
                        acc_d   = 32'h0;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        acc_d   = (req_op == OpSubMix) ? 32'h0 : req_key;
                        err_d   = 1'b0;
                        state_d = (req_op == OpMix) ? StMix : StSub;
                    end
                end
            end
            StSub: begin
                acc_d = acc_q ^ dp_rd;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    if (op_q == OpSubMix) begin
                        // Substituted column becomes the MixColumns input; key seeds the sum.
                        state_d = StMix;
                        work_d  = acc_q ^ dp_rd;
                        acc_d   = key_q;
                        cnt_d   = 2'd0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StMix: begin
                acc_d = acc_q ^ dp_rd;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = StDone;
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            work_q  <= 32'h0;
            acc_q   <= 32'h0;
            key_q   <= 32'h0;
            dec_q   <= 1'b0;
            op_q    <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_data  = rsp_valid ? acc_q : 32'h0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_aes_v3_2_col_seq.sv
// Directed bench for the column sequencer: known AES vectors, illegal ops,
// backpressure and mid-operation reset.
module tb_aes_v3_2_col_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid2 = 1'b0;
    logic        req_dec = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_data = 32'h0;
    logic [31:0] req_key = 32'h0;
    logic        rsp_ready = 1'b0;
    logic        rsp_ready2 = 1'b0;
    logic        req_ready, req_ready2;
    logic        rsp_valid, rsp_valid2;
    logic [31:0] rsp_data, rsp_data2;
    logic        rsp_err, rsp_err2;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    aes_v3_2_col_seq #(.SUBMIX_EN(1'b1)) dut (
        .g_clk(clk), .g_reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_dec(req_dec), .req_op(req_op),
        .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    aes_v3_2_col_seq #(.SUBMIX_EN(1'b0)) dut_nosm (
        .g_clk(clk), .g_reset(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_dec(req_dec), .req_op(req_op),
        .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .rsp_err(rsp_err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from idle; exp_lat counts edges after the accept edge.
    task automatic run_op(input string tag, input logic dec, input logic [1:0] op,
                          input logic [31:0] data, input logic [31:0] key,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input bit ack);
        int lat;
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_dec = dec; req_op = op; req_data = data; req_key = key; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        if (ack) begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check({tag, "_idle"}, {30'h0, rsp_valid, req_ready}, 32'h1);
        end
    endtask

    task automatic run_op2(input string tag, input logic [1:0] op, input logic [31:0] data,
                           input logic [31:0] key, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_lat);
        int lat;
        req_dec = 1'b0; req_op = op; req_data = data; req_key = key; req_valid2 = 1'b1;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        lat = 0;
        while (!rsp_valid2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, rsp_data2, exp_data);
        check({tag, "_err"}, {31'h0, rsp_err2}, {31'h0, exp_err});
        rsp_ready2 = 1'b1;
        @(posedge clk); #1;
        rsp_ready2 = 1'b0;
        check({tag, "_idle"}, {30'h0, rsp_valid2, req_ready2}, 32'h1);
    endtask

    initial begin
        logic [31:0] held;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_data", rsp_data, 32'h0);
        check("rst_err", {31'h0, rsp_err}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("sub_enc0", 1'b0, 2'b00, 32'h00000000, 32'h0, 32'h63636363, 1'b0, 4, 1'b1);
        run_op("sub_dec", 1'b1, 2'b00, 32'h63636363, 32'h0, 32'h00000000, 1'b0, 4, 1'b1);
        // bytes 00,01,53,10 -> 63,7c,ed,ca, then inverted by the all-ones key
        run_op("sub_key", 1'b0, 2'b00, 32'h10530100, 32'hffffffff, 32'h3512839c, 1'b0, 4, 1'b1);
        run_op("mix_enc", 1'b0, 2'b01, 32'h455313db, 32'h0, 32'hbca14d8e, 1'b0, 4, 1'b1);
        run_op("mix_dec", 1'b1, 2'b01, 32'hbca14d8e, 32'h0, 32'h455313db, 1'b0, 4, 1'b1);
        run_op("submix_enc", 1'b0, 2'b10, 32'h0, 32'h12345678, 32'h7157351b, 1'b0, 8, 1'b1);
        run_op("submix_dec", 1'b1, 2'b10, 32'h63636363, 32'h0, 32'h00000000, 1'b0, 8, 1'b1);
        // Illegal ops reach DONE on the accept edge itself.
        run_op("illegal", 1'b0, 2'b11, 32'h455313db, 32'h12345678, 32'h0, 1'b1, 0, 1'b1);
        run_op("after_ill", 1'b0, 2'b00, 32'h0, 32'h0, 32'h63636363, 1'b0, 4, 1'b1);

        run_op2("nosm_submix", 2'b10, 32'h0, 32'h12345678, 32'h0, 1'b1, 0);
        run_op2("nosm_sub", 2'b00, 32'h0, 32'h0, 32'h63636363, 1'b0, 4);

        // Backpressure: response held while a competing request is presented.
        run_op("bp", 1'b0, 2'b01, 32'h455313db, 32'h0, 32'hbca14d8e, 1'b0, 4, 1'b0);
        held = rsp_data;
        req_op = 2'b00; req_data = 32'hdeadbeef; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {29'h0, rsp_valid, req_ready, rsp_err}, 32'h4);
            check("bp_data", rsp_data, held);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_release", {30'h0, rsp_valid, req_ready}, 32'h1);

        // Reset in the first MIX cycle of a SUBMIX.
        req_dec = 1'b0; req_op = 2'b10; req_data = 32'h0; req_key = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_out", {29'h0, req_ready, rsp_valid, rsp_err}, 32'h4);
        check("mrst_data", rsp_data, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check("mrst_norsp", {30'h0, rsp_valid, req_ready}, 32'h1);
        run_op("post_rst", 1'b0, 2'b00, 32'h10530100, 32'h0, 32'hcaed7c63, 1'b0, 4, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
